// File: rtl/data_mem_responder_if.sv
// Load/store handshake between the core and the data-memory responder.
// Signal names keep the responder's point of view (_i into it, _o out of it).
interface data_mem_responder_if;
  logic        valid_i;
  logic        wen_i;
  logic        byte_not_word_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic        yumi_i;
  logic        yumi_o;
  logic        valid_o;
  logic [31:0] read_data_o;
  logic        err_o;

  modport slave (
    input  valid_i, wen_i, byte_not_word_i, addr_i, write_data_i, yumi_i,
    output yumi_o, valid_o, read_data_o, err_o
  );

  modport master (
    output valid_i, wen_i, byte_not_word_i, addr_i, write_data_i, yumi_i,
    input  yumi_o, valid_o, read_data_o, err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, performs it at the
// accept edge, and presents the result after a fixed latency until consumed.
module data_mem_responder #(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   mem_bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int depth_lp = 1 << addr_width_p;

  state_e      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] read_data_r;
  logic        err_r;
  logic        valid_r;

  logic [31:0] mem_r [depth_lp];

  logic                    accept;
  logic [addr_width_p-1:0] word_idx;
  logic [1:0]              lane;
  logic                    misaligned;
  logic [31:0]             mem_word;
  logic [7:0]              lane_byte;
  logic                    unused_addr_bits;

  assign accept         = mem_bus.valid_i & (state_r == IDLE) & reset;
  assign mem_bus.yumi_o = accept;

  // Upper address bits are dropped so accesses wrap modulo the memory size.
  assign word_idx         = mem_bus.addr_i[addr_width_p+1:2];
  assign lane             = mem_bus.addr_i[1:0];
  assign unused_addr_bits = ^mem_bus.addr_i[31:addr_width_p+2];
  assign misaligned       = ~mem_bus.byte_not_word_i & (lane != 2'b00);
  assign mem_word         = mem_r[word_idx];
  assign lane_byte        = mem_word[{lane, 3'b000} +: 8];

  // The array has no reset so stored data survives a core reset.
  always_ff @(posedge clk) begin
    if (accept && mem_bus.wen_i && !misaligned) begin
      if (mem_bus.byte_not_word_i)
        mem_r[word_idx][{lane, 3'b000} +: 8] <= mem_bus.write_data_i[7:0];
      else
        mem_r[word_idx] <= mem_bus.write_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      read_data_r <= 32'd0;
      err_r       <= 1'b0;
      valid_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept) begin
            err_r <= misaligned;
            if (misaligned || mem_bus.wen_i)
              read_data_r <= 32'd0;
            else if (mem_bus.byte_not_word_i)
              read_data_r <= {24'd0, lane_byte};
            else
              read_data_r <= mem_word;
            if (latency_p == 1) begin
              state_r <= RESP;
              valid_r <= 1'b1;
            end else begin
              state_r <= WAIT;
              cnt_r   <= 4'(latency_p - 2);
            end
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= RESP;
            valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (mem_bus.yumi_i) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Response fields are gated so they read as zero outside a valid response.
  assign mem_bus.valid_o     = valid_r;
  assign mem_bus.read_data_o = valid_r ? read_data_r : 32'd0;
  assign mem_bus.err_o       = valid_r & err_r;

endmodule
